// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus select codes and write-side FSM encoding
package bus_pkg;
   localparam int DATA_W = 16;
   localparam int SEL_W  = 4;

   // Also imported by the read mux so both sides decode identical codes.
   localparam logic [SEL_W-1:0] SEL_TP1 = 4'd1;
   localparam logic [SEL_W-1:0] SEL_TP2 = 4'd2;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_WRITE = 1'b1;
endpackage

// File: rtl/bus_demux_writer_if.sv
// rtl/bus_demux_writer_if.sv - bus word handshake into the demux writer
interface bus_demux_writer_if;
   import bus_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [SEL_W-1:0]  select;
   logic [DATA_W-1:0] data_in;

   modport master (output in_valid, output select, output data_in, input in_ready);
   modport slave  (input in_valid, input select, input data_in, output in_ready);
endinterface

// File: rtl/bus_demux_writer.sv
// rtl/bus_demux_writer.sv - loads one accepted bus word into TP1 or TP2
module bus_demux_writer
   import bus_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   bus_demux_writer_if.slave  bus,
   input  logic [1:0]         dest_busy,
   output logic [DATA_W-1:0]  tp1,
   output logic [DATA_W-1:0]  tp2,
   output logic               tp1_load,
   output logic               tp2_load,
   output logic               done,
   output logic               err
);

   logic [0:0]        state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] tp1_q, tp1_d;
   logic [DATA_W-1:0] tp2_q, tp2_d;
   logic              tp1_load_q, tp1_load_d;
   logic              tp2_load_q, tp2_load_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   assign bus.in_ready = (state_q == ST_IDLE);

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      data_d     = data_q;
      tp1_d      = tp1_q;
      tp2_d      = tp2_q;
      tp1_load_d = 1'b0;
      tp2_load_d = 1'b0;
      done_d     = 1'b0;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               sel_d   = bus.select;
               data_d  = bus.data_in;
               state_d = ST_WRITE;
            end
         end
         default: begin
            // A busy destination holds the word here indefinitely.
            case (sel_q)
               SEL_TP1: begin
                  if (!dest_busy[0]) begin
                     tp1_d      = data_q;
                     tp1_load_d = 1'b1;
                     done_d     = 1'b1;
                     state_d    = ST_IDLE;
                  end
               end
               SEL_TP2: begin
                  if (!dest_busy[1]) begin
                     tp2_d      = data_q;
                     tp2_load_d = 1'b1;
                     done_d     = 1'b1;
                     state_d    = ST_IDLE;
                  end
               end
               default: begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            endcase
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         data_q     <= '0;
         tp1_q      <= '0;
         tp2_q      <= '0;
         tp1_load_q <= 1'b0;
         tp2_load_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         data_q     <= data_d;
         tp1_q      <= tp1_d;
         tp2_q      <= tp2_d;
         tp1_load_q <= tp1_load_d;
         tp2_load_q <= tp2_load_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign tp1      = tp1_q;
   assign tp2      = tp2_q;
   assign tp1_load = tp1_load_q;
   assign tp2_load = tp2_load_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_bus_demux_writer.sv
// tb/tb_bus_demux_writer.sv - self-checking bench for bus_demux_writer
module tb_bus_demux_writer;
   import bus_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  dest_busy;
   logic [15:0] tp1, tp2;
   logic        tp1_load, tp2_load, done, err;

   bus_demux_writer_if bus_if ();

   bus_demux_writer dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if.slave),
      .dest_busy (dest_busy),
      .tp1       (tp1),
      .tp2       (tp2),
      .tp1_load  (tp1_load),
      .tp2_load  (tp2_load),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] tp1;
      logic [15:0] tp2;
      logic        ld1;
      logic        ld2;
      logic        err;
   } exp_t;

   typedef struct {
      logic [3:0]  sel;
      logic [15:0] data;
      logic [1:0]  busy;
      logic [15:0] tp1;
      logic [15:0] tp2;
      logic        ld1;
      logic        ld2;
      logic        err;
   } vec_t;

   exp_t        sb_q[$];
   vec_t        vecs[9];
   int          n_vec = 0;
   int          n_bad = 0;
   int          acc_cnt = 0;
   logic [15:0] m_tp1 = '0;
   logic [15:0] m_tp2 = '0;
   logic        m_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   // Present a word, wait for in_ready, record the expected retirement.
   task automatic send(input logic [3:0] sel, input logic [15:0] data);
      exp_t e;
      bit   got = 1'b0;
      bus_if.in_valid = 1'b1;
      bus_if.select   = sel;
      bus_if.data_in  = data;
      for (int i = 0; i < 20; i++) begin
         if (bus_if.in_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!got) begin
         check("accept_timeout", 32'd0, 32'd1);
         bus_if.in_valid = 1'b0;
      end else begin
         e.ld1 = (sel == SEL_TP1);
         e.ld2 = (sel == SEL_TP2);
         if (e.ld1) m_tp1 = data;
         if (e.ld2) m_tp2 = data;
         if (!e.ld1 && !e.ld2) m_err = 1'b1;
         e.tp1 = m_tp1;
         e.tp2 = m_tp2;
         e.err = m_err;
         sb_q.push_back(e);
         @(negedge clk);
      end
   endtask

   task automatic wait_done();
      bit got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("done_timeout", 32'd0, 32'd1);
   endtask

   always @(posedge clk) begin
      if (!rst && bus_if.in_valid && bus_if.in_ready) acc_cnt++;
   end

   always @(posedge clk) begin : scoreboard
      exp_t e;
      #2;
      if (!rst) begin
         if ((tp1_load || tp2_load) && !done)
            check("strobe_without_done", {30'd0, tp1_load, tp2_load}, 32'd0);
         if (done) begin
            if (sb_q.size() == 0) begin
               check("done_unexpected", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("sb_tp1", {16'd0, tp1}, {16'd0, e.tp1});
               check("sb_tp2", {16'd0, tp2}, {16'd0, e.tp2});
               check("sb_loads", {30'd0, tp1_load, tp2_load}, {30'd0, e.ld1, e.ld2});
               check("sb_err", {31'd0, err}, {31'd0, e.err});
            end
         end
      end
   end

   initial begin
      vecs[0] = '{4'd2,  16'h0BAD, 2'b01, 16'hA5A5, 16'h0BAD, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{4'd1,  16'h0F0F, 2'b10, 16'h0F0F, 16'h0BAD, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{4'd1,  16'h0F0F, 2'b00, 16'h0F0F, 16'h0BAD, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{4'd2,  16'hFFFF, 2'b00, 16'h0F0F, 16'hFFFF, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{4'd7,  16'hFFFF, 2'b11, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{4'd0,  16'h0000, 2'b00, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{4'd1,  16'h1357, 2'b00, 16'h1357, 16'hFFFF, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{4'd15, 16'h2468, 2'b00, 16'h1357, 16'hFFFF, 1'b0, 1'b0, 1'b1};
      vecs[8] = '{4'd3,  16'hAAAA, 2'b01, 16'h1357, 16'hFFFF, 1'b0, 1'b0, 1'b1};

      rst = 1'b1;
      dest_busy = 2'b00;
      bus_if.in_valid = 1'b0;
      bus_if.select = '0;
      bus_if.data_in = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Idle after reset.
      for (int i = 0; i < 5; i++) begin
         check("idle_tp1", {16'd0, tp1}, 32'd0);
         check("idle_tp2", {16'd0, tp2}, 32'd0);
         check("idle_ready", {31'd0, bus_if.in_ready}, 32'd1);
         check("idle_flags", {28'd0, tp1_load, tp2_load, done, err}, 32'd0);
         @(negedge clk);
      end

      // Single unstalled write: in_ready low exactly one cycle.
      send(4'd1, 16'hA5A5);
      bus_if.in_valid = 1'b0;
      check("a5_ready_low", {31'd0, bus_if.in_ready}, 32'd0);
      check("a5_no_done_yet", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("a5_ready_back", {31'd0, bus_if.in_ready}, 32'd1);
      check("a5_done", {31'd0, done}, 32'd1);
      check("a5_tp1", {16'd0, tp1}, 32'h0000A5A5);
      check("a5_tp2", {16'd0, tp2}, 32'd0);
      @(negedge clk);
      check("a5_pulse_len", {30'd0, tp1_load, done}, 32'd0);

      // Stalled TP2 write; data_in changes during the stall.
      dest_busy = 2'b10;
      send(4'd2, 16'h1234);
      bus_if.in_valid = 1'b0;
      bus_if.data_in = 16'hDEAD;
      bus_if.select = 4'd1;
      for (int i = 0; i < 3; i++) begin
         check("stall_no_load", {30'd0, tp2_load, done}, 32'd0);
         check("stall_ready", {31'd0, bus_if.in_ready}, 32'd0);
         check("stall_tp2", {16'd0, tp2}, 32'd0);
         @(negedge clk);
      end
      dest_busy = 2'b00;
      wait_done();
      check("stall_tp2_final", {16'd0, tp2}, 32'h00001234);
      check("stall_tp1_kept", {16'd0, tp1}, 32'h0000A5A5);
      @(negedge clk);
      check("stall_single_pulse", {31'd0, tp2_load}, 32'd0);

      // Table vectors.
      foreach (vecs[i]) begin
         dest_busy = vecs[i].busy;
         send(vecs[i].sel, vecs[i].data);
         bus_if.in_valid = 1'b0;
         wait_done();
         check($sformatf("vec%0d_tp1", i), {16'd0, tp1}, {16'd0, vecs[i].tp1});
         check($sformatf("vec%0d_tp2", i), {16'd0, tp2}, {16'd0, vecs[i].tp2});
         check($sformatf("vec%0d_loads", i), {30'd0, tp1_load, tp2_load},
               {30'd0, vecs[i].ld1, vecs[i].ld2});
         check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
      end
      dest_busy = 2'b00;
      @(negedge clk);

      // Back-to-back stream with in_valid held high.
      begin
         int acc0;
         acc0 = acc_cnt;
         send(4'd1, 16'h0001);
         send(4'd2, 16'h0002);
         send(4'd1, 16'h0003);
         bus_if.in_valid = 1'b0;
         @(negedge clk);
         check("b2b_accepts", acc_cnt - acc0, 32'd3);
         check("b2b_done", {31'd0, done}, 32'd1);
         check("b2b_tp1", {16'd0, tp1}, 32'h00000003);
         check("b2b_tp2", {16'd0, tp2}, 32'h00000002);
      end
      @(negedge clk);

      // Reset during WRITE discards the held word.
      bus_if.in_valid = 1'b1;
      bus_if.select = 4'd1;
      bus_if.data_in = 16'hBEEF;
      check("rst_pre_ready", {31'd0, bus_if.in_ready}, 32'd1);
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      rst = 1'b1;
      check("rst_in_write", {31'd0, bus_if.in_ready}, 32'd0);
      m_tp1 = '0;
      m_tp2 = '0;
      m_err = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("rst_tp1", {16'd0, tp1}, 32'd0);
      check("rst_tp2", {16'd0, tp2}, 32'd0);
      check("rst_flags", {28'd0, tp1_load, tp2_load, done, err}, 32'd0);
      check("rst_ready", {31'd0, bus_if.in_ready}, 32'd1);
      @(negedge clk);
      check("rst_after_flags", {28'd0, tp1_load, tp2_load, done, err}, 32'd0);
      check("rst_after_tp1", {16'd0, tp1}, 32'd0);

      check("sb_drained", sb_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
